// File: rtl/switch_debounce_pkg.sv
// Shared types and constants for the DIP-switch debouncer.
// The FSM state enum, counter width and default settle length live here
// so the bank sub-module and the top agree on them.
package switch_debounce_pkg;

   typedef enum logic {
      SETTLE = 1'b0,
      STABLE = 1'b1
   } db_state_t;

   localparam int CNT_W                   = 20;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 480000;

endpackage

// File: rtl/debounce_nibble_co.sv
// Debouncer for one 4-bit switch bank: 2-flop synchronizer, candidate
// register, 20-bit settle counter and a SETTLE/STABLE FSM.
// Optional macro SWDB_CHANGE_PULSE_EN adds the will_change output, which
// flags that the coming edge commits a value different from the current one.
module debounce_nibble_co
   import switch_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] raw,
   output logic [3:0] value,
   output logic       committed
`ifdef SWDB_CHANGE_PULSE_EN
   ,
   output logic       will_change
`endif
);

   // Counter value from which the next matching edge completes the settle run.
   localparam logic [CNT_W-1:0] LAST_INC = CNT_W'(DEBOUNCE_CYCLES - 2);

   logic [3:0]       sync_meta;
   logic [3:0]       sync_out;
   logic [3:0]       candidate;
   logic [CNT_W-1:0] count;
   logic [2:0]       prime;
   db_state_t        state;
   logic             same;
   logic             commit_now;

   assign same       = (sync_out == candidate);
   assign commit_now = (state == SETTLE) && prime[2] && same && (count == LAST_INC);

`ifdef SWDB_CHANGE_PULSE_EN
   assign will_change = commit_now && (candidate != value);
`endif

   // Two-flop synchronizer; nothing downstream ever sees the raw input.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= '0;
         sync_out  <= '0;
      end else begin
         sync_meta <= raw;
         sync_out  <= sync_meta;
      end
   end

   // Settle FSM. The prime shift register keeps the counter cleared until the
   // synchronizer holds a real sample, so the first commit after reset takes
   // the full latency even when the switches already read zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         candidate <= '0;
         count     <= '0;
         prime     <= '0;
         value     <= '0;
         committed <= 1'b0;
         state     <= SETTLE;
      end else begin
         prime <= {prime[1:0], 1'b1};
         case (state)
            SETTLE: begin
               if (!prime[2]) begin
                  count <= '0;
                  if (prime[1]) begin
                     candidate <= sync_out;
                  end
               end else if (!same) begin
                  candidate <= sync_out;
                  count     <= '0;
               end else if (commit_now) begin
                  count     <= count + 1'b1;
                  value     <= candidate;
                  committed <= 1'b1;
                  state     <= STABLE;
               end else if (count < LAST_INC) begin
                  count <= count + 1'b1;
               end
            end
            STABLE: begin
               if (sync_out != value) begin
                  candidate <= sync_out;
                  count     <= '0;
                  state     <= SETTLE;
               end
            end
            default: begin
               state <= SETTLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/switch_debounce_co.sv
// Two-bank DIP-switch debouncer feeding the display/sum stage.
// Each bank settles independently; valid goes high once both have committed.
// Optional macro SWDB_CHANGE_PULSE_EN adds the one-cycle 'changed' output.
module switch_debounce_co
   import switch_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] sw1_raw,
   input  logic [3:0] sw2_raw,
   output logic [3:0] s1,
   output logic [3:0] s2,
   output logic       valid
`ifdef SWDB_CHANGE_PULSE_EN
   ,
   output logic       changed
`endif
);

   logic done1;
   logic done2;

`ifdef SWDB_CHANGE_PULSE_EN
   logic change1;
   logic change2;
`endif

   debounce_nibble_co #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_bank1 (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw        (sw1_raw),
      .value      (s1),
      .committed  (done1)
`ifdef SWDB_CHANGE_PULSE_EN
      ,
      .will_change(change1)
`endif
   );

   debounce_nibble_co #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_bank2 (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw        (sw2_raw),
      .value      (s2),
      .committed  (done2)
`ifdef SWDB_CHANGE_PULSE_EN
      ,
      .will_change(change2)
`endif
   );

   // Both sticky commit flags are registers, so valid rises on the edge the
   // later bank first commits and stays up until reset.
   assign valid = done1 & done2;

`ifdef SWDB_CHANGE_PULSE_EN
   // One pulse for any edge where either bank commits a new value; both
   // banks changing together still give a single pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         changed <= 1'b0;
      end else begin
         changed <= change1 | change2;
      end
   end
`endif

endmodule
